// File: rtl/imem_prog_loader.sv
`timescale 1ns/1ps
// imem_prog_loader
//   Boot-time loader in front of the MIPS core's instruction memory.
//   The input stream is a 2-byte big-endian word count followed by the
//   program bytes, also big-endian. The loader writes one 32-bit word per
//   im_we pulse, starting at byte address 0. It keeps the core frozen
//   (cpu_hold) until the whole program is in memory, then releases it
//   with a single pc_clear pulse.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start               begin a load (honoured in IDLE/DONE/ERROR only)
//   in_data/in_valid    byte stream; in_ready = loader accepts this cycle
//   im_we/im_addr/      instruction-memory write port (byte address,
//   im_wdata            word aligned)
//   cpu_hold, pc_clear  core freeze and PC-clear-on-release pulse
//   busy, done, err     status; done and err are sticky until next start
//   words_loaded        words written by the current/last load
module imem_prog_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH+1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_hold,
    output logic                  pc_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    // Memory depth in words; one bit wider than len so a full-depth count fits.
    localparam logic [LEN_WIDTH:0] DEPTH = {{LEN_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

    logic [2:0]           state;
    logic [7:0]           len_hi;
    logic [LEN_WIDTH-1:0] len;
    logic [1:0]           bidx;
    logic [23:0]          sr;      // first three bytes of the word in progress
    logic                 accept;
    logic [LEN_WIDTH-1:0] len_nxt;

    // Header is two bytes; the high byte is zero-extended/truncated to LEN_WIDTH.
    assign len_nxt = LEN_WIDTH'({len_hi, in_data});

    always_comb begin
        in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            len_hi       <= '0;
            len          <= '0;
            bidx         <= '0;
            sr           <= '0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            cpu_hold     <= 1'b1;
            pc_clear     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            im_we    <= 1'b0;
            pc_clear <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_LEN_HI;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        bidx         <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= in_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len <= len_nxt;
                        if (len_nxt == '0) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            pc_clear <= 1'b1;
                        end else if ({1'b0, len_nxt} > DEPTH) begin
                            state <= S_ERROR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // words_loaded already counts the word being written, so
                    // equality with len during im_we marks the final write.
                    if (im_we && (LEN_WIDTH'(words_loaded) == len)) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        pc_clear <= 1'b1;
                    end else if (accept) begin
                        sr   <= {sr[15:0], in_data};
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            im_we        <= 1'b1;
                            im_wdata     <= {sr, in_data};
                            im_addr      <= {words_loaded[ADDR_WIDTH-1:0], 2'b00};
                            words_loaded <= words_loaded + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
`timescale 1ns/1ps
module tb_imem_prog_loader;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, im_we, cpu_hold, pc_clear, busy, done, err;
    logic [AW+1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   words_loaded;

    imem_prog_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .im_we(im_we),
        .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
        .pc_clear(pc_clear), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0]    stream[$];
    logic [AW+1:0] got_a[$];
    logic [31:0]   got_d[$];
    int pcc_n = 0, pcc_cyc = -1, lastwe_cyc = -1;

    // Observe the memory write port and the release pulse away from the edge.
    always @(negedge clk) begin
        cyc++;
        if (im_we === 1'b1) begin
            got_a.push_back(im_addr);
            got_d.push_back(im_wdata);
            lastwe_cyc = cyc;
        end
        if (pc_clear === 1'b1) begin
            pcc_n++;
            pcc_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_im_we"}, im_we, 0);
        chk({tag, "_im_addr"}, im_addr, 0);
        chk({tag, "_im_wdata"}, im_wdata, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 1);
        chk({tag, "_pc_clear"}, pc_clear, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_words"}, words_loaded, 0);
    endtask

    // Send the first `count` bytes of stream; random idle gaps up to gap_max
    // cycles before each byte; optionally pulse start alongside byte start_at.
    task automatic send_stream(input int count, input int gap_max, input int start_at);
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = stream[i];
            if (i == start_at) start = 1'b1;
            for (int n = 0; n < 50 && !in_ready; n++) begin
                @(negedge clk);
                start = 1'b0;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic mk_prog3();
        stream.delete();
        stream = '{8'h00, 8'h03,
                   8'h20, 8'h08, 8'h00, 8'h05,
                   8'h20, 8'h09, 8'h00, 8'h07,
                   8'hAC, 8'h08, 8'h00, 8'h00};
    endtask

    task automatic mk_rand(input int nwords);
        stream.delete();
        stream.push_back(8'(nwords >> 8));
        stream.push_back(8'(nwords));
        for (int i = 0; i < 4 * nwords; i++) stream.push_back(8'($urandom));
    endtask

    task automatic pulse_start();
        got_a.delete(); got_d.delete();
        pcc_n = 0; pcc_cyc = -1; lastwe_cyc = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full load of `stream`, then compare against the expected outcome
    // worked out directly from the stream contents.
    task automatic do_load(input string nm, input int gap_max, input int start_at);
        int len, nexp;
        bit exp_err;
        len     = {stream[0], stream[1]};
        exp_err = (len > (1 << AW));
        nexp    = exp_err ? 0 : len;

        pulse_start();
        chk({nm, "_busy_start"}, busy, 1);
        chk({nm, "_hold_start"}, cpu_hold, 1);
        chk({nm, "_done_clr"}, done, 0);
        chk({nm, "_words_clr"}, words_loaded, 0);

        send_stream(stream.size(), gap_max, start_at);
        for (int n = 0; n < 20 && !(done || err); n++) @(negedge clk);
        repeat (3) @(negedge clk);

        chk({nm, "_done"}, done, !exp_err);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_hold"}, cpu_hold, exp_err);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_in_ready"}, in_ready, 0);
        chk({nm, "_words"}, words_loaded, nexp);
        chk({nm, "_nwrites"}, got_a.size(), nexp);
        chk({nm, "_pcclr_n"}, pcc_n, exp_err ? 0 : 1);
        if (!exp_err && nexp > 0)
            chk({nm, "_pcclr_when"}, pcc_cyc, lastwe_cyc + 1);
        for (int i = 0; i < nexp && i < got_a.size(); i++) begin
            chk($sformatf("%s_addr%0d", nm, i), got_a[i], 4 * i);
            chk($sformatf("%s_data%0d", nm, i), got_d[i],
                {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        mk_prog3();
        do_load("prog3", 0, -1);

        stream = '{8'h00, 8'h00};
        do_load("len0", 0, -1);

        stream = '{8'h01, 8'h01};
        do_load("len257", 0, -1);
        mk_rand(1);
        do_load("after_err", 0, -1);

        mk_prog3();
        do_load("prog3_gaps", 3, -1);

        mk_prog3();
        do_load("start_in_data", 0, 6);

        for (int r = 0; r < 3; r++) begin
            mk_rand($urandom_range(1, 8));
            do_load($sformatf("rand%0d", r), 2, -1);
        end

        mk_rand(1 << AW);
        do_load("full_depth", 0, -1);

        // Reset in the middle of a load: header plus six data bytes.
        mk_prog3();
        pulse_start();
        send_stream(8, 0, -1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_load("post_reset", 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle MIPS core's instruction memory.
- Receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into instruction memory from byte address 0.
- Holds the core (PC and clock-enable) frozen until the load completes, then releases it with a one-cycle PC-clear pulse.
- Replaces testbench-side memory-file preloading for system-level runs.

Parameters:
- ADDR_WIDTH, 8, word-address width; instruction memory depth is 2**ADDR_WIDTH words.
- LEN_WIDTH, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE, ERROR
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte this cycle
- im_we  output  1  instruction-memory word write strobe
- im_addr  output  ADDR_WIDTH+2  byte address of the word being written (low 2 bits always 0)
- im_wdata  output  32  instruction word, big-endian assembled
- cpu_hold  output  1  high keeps the core's PC and register/data-memory writes frozen
- pc_clear  output  1  one-cycle pulse forcing PC to 0 at release
- busy  output  1  load in progress
- done  output  1  sticky; program loaded, core running
- err  output  1  sticky; header length exceeded memory depth
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current or last load

Behaviour:
- Reset values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, pc_clear=0, busy=0, done=0, err=0, words_loaded=0, state=IDLE. The core is held out of reset until the first successful load.
- Byte transfer occurs only on a cycle with in_valid && in_ready. in_ready=1 in LEN_HI, LEN_LO and DATA; otherwise 0. There is no back-pressure inside a load.
- States:
  - IDLE: start -> LEN_HI; set busy=1, cpu_hold=1, done=0, err=0, words_loaded=0, byte index=0, word index=0.
  - LEN_HI: accepted byte becomes len[15:8] -> LEN_LO.
  - LEN_LO: accepted byte becomes len[7:0]. Then:
    - len==0 -> DONE.
    - len > 2**ADDR_WIDTH -> ERROR.
    - otherwise -> DATA.
  - DATA: bytes shift into the word, first byte to [31:24]. On the 4th byte of a word, the next cycle registers im_we=1 for exactly one cycle, with im_wdata = the assembled word and im_addr = word_index*4. words_loaded increments in the same cycle as im_we. Byte index wraps 3->0. When the write of word len-1 occurs -> DONE; the FSM is in DONE on the cycle after that im_we.
  - DONE (entry): busy=0, done=1, cpu_hold=0, and pc_clear=1 for the first DONE cycle only. start -> LEN_HI, re-asserting cpu_hold the cycle after start.
  - ERROR: busy=0, err=1, cpu_hold=1, no writes. start -> LEN_HI.
- Latency: im_we appears 1 cycle after the 4th accepted byte. DONE is entered 1 cycle after the last im_we. Minimum load of N words is 4N+2 accepted bytes plus 2 cycles.
- Gaps in in_valid stall assembly without corrupting partial-word state. There is no timeout.
- start while busy is ignored; the load continues unchanged.
- Asynchronous rst_n mid-load returns all outputs to reset values immediately. Any partially written memory contents are undefined.
- len is compared as unsigned against 2**ADDR_WIDTH; words_loaded is wide enough to hold a full-depth count.

Test Plan:
- Load header 0x0003 then bytes 20 08 00 05 / 20 09 00 07 / AC 08 00 00 -> im_we pulses at im_addr 0,4,8 with wdata 20080005, 20090007, AC080000; words_loaded=3; pc_clear pulses once the cycle after the last write; cpu_hold falls; done=1.
- Header 0x0000 -> DONE directly after the 2nd byte, no im_we, pc_clear pulse, done=1, words_loaded=0.
- ADDR_WIDTH=8, header 0x0101 (257) -> ERROR, err=1, cpu_hold stays 1, in_ready=0, no im_we. Then start plus a valid 1-word load -> done=1, err=0.
- Random in_valid deasserts (including mid-word and between header bytes) on the 3-word program -> identical writes and data to the gap-free case.
- start pulsed during DATA -> ignored; word sequence and count unchanged.
- rst_n low after 6 data bytes -> all outputs return to reset values asynchronously, cpu_hold=1. A subsequent start plus full stream loads correctly from address 0.
